// File: rtl/usb_uart_pkg.sv
// rtl/usb_uart_pkg.sv - shared FSM state types and baud divisor helper for the USB/UART bridge
package usb_uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/bridge_byte_fifo.sv
// rtl/bridge_byte_fifo.sv - first-word-fall-through byte FIFO with wrap-bit full/empty detection
module bridge_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Fullness is judged before any same-cycle pop, so a full FIFO never passes data through.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/usb_uart_bridge.sv
// rtl/usb_uart_bridge.sv - CDC byte stream to 8N1 UART bridge with TX and RX FIFOs
module usb_uart_bridge #(
  parameter int CLK_HZ   = 48000000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       outport_valid_i,
  input  logic [7:0] outport_data_i,
  output logic       outport_accept_o,
  output logic       inport_valid_o,
  output logic [7:0] inport_data_o,
  input  logic       inport_accept_i,
  input  logic       uart_rx_i,
  output logic       uart_tx_o,
  output logic       rx_overrun_o,
  output logic       rx_frame_err_o
);
  import usb_uart_pkg::*;

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  tx_state_e     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic [7:0]    tx_head;
  logic          tx_full, tx_empty, tx_pop;

  rx_state_e     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_meta, rx_s;
  logic          rx_full, rx_empty, rx_push;

  bridge_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_i), .rst(rst_i), .push(outport_valid_i), .push_data(outport_data_i),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  bridge_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk_i), .rst(rst_i), .push(rx_push), .push_data(rx_sh),
    .pop(inport_accept_i), .head(inport_data_o), .full(rx_full), .empty(rx_empty)
  );

  assign outport_accept_o = !tx_full;
  assign inport_valid_o   = !rx_empty;
  // The head is taken both from IDLE and at the end of a stop bit, giving gapless frames.
  assign tx_pop  = !tx_empty && ((tx_state == TX_IDLE) ||
                                 (tx_state == TX_STOP && tx_cnt == DIV_LAST));
  assign rx_push = (rx_state == RX_STOP) && (rx_cnt == DIV_LAST) && rx_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      uart_tx_o <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx_o <= 1'b1;
          if (!tx_empty) begin
            tx_sh     <= tx_head;
            tx_cnt    <= '0;
            tx_state  <= TX_START;
            uart_tx_o <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt    <= '0;
            tx_bit    <= '0;
            uart_tx_o <= tx_sh[0];
            tx_sh     <= {1'b0, tx_sh[7:1]};
            tx_state  <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx_o <= 1'b1;
              tx_state  <= TX_STOP;
            end else begin
              uart_tx_o <= tx_sh[0];
              tx_sh     <= {1'b0, tx_sh[7:1]};
              tx_bit    <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (!tx_empty) begin
              tx_sh     <= tx_head;
              uart_tx_o <= 1'b0;
              tx_state  <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      rx_state       <= RX_IDLE;
      rx_cnt         <= '0;
      rx_bit         <= '0;
      rx_sh          <= '0;
      rx_overrun_o   <= 1'b0;
      rx_frame_err_o <= 1'b0;
    end else begin
      rx_meta        <= uart_rx_i;
      rx_s           <= rx_meta;
      rx_overrun_o   <= 1'b0;
      rx_frame_err_o <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start resample rejects short low glitches silently.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt         <= '0;
            rx_state       <= RX_IDLE;
            rx_frame_err_o <= !rx_s;
            rx_overrun_o   <= rx_s && rx_full;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
